// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the reference borrow function.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  function automatic logic sub_borrow(
    input logic x,
    input logic y,
    input logic bi
  );
    return (~x & y) | (y & bi) | (~x & bi);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi.
// Reused once per clock by the serial datapath.
module fs_cell
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = sub_borrow(x, y, bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock, start/ready/done.
// Optional self-check of each result: define SERIAL_SUB_CHECK_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  sub_state_e       state;
  sub_state_e       nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brr;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;
  logic             last;

  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  fs_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brr),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: accept, run WIDTH bits, pulse done
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per cycle, latch result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      brr  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brr  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          brr  <= cell_bo;
          d_sh <= {cell_d, d_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            diff <= {cell_d, d_sh[WIDTH-1:1]};
            bout <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_CHECK_EN
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             sh_bin;
  logic [WIDTH:0]   ref_res;

  assign ref_res = {1'b0, sh_a} - {1'b0, sh_b} - (WIDTH+1)'(sh_bin);

  // Shadow operands taken on the accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_bin <= 1'b0;
    end else if (state == IDLE && start) begin
      sh_a   <= a;
      sh_b   <= b;
      sh_bin <= bin;
    end
  end

  // Compare the serial result with a parallel subtraction
  always_ff @(posedge clk) begin
    if (!rst && state == DONE) begin
      assert ({bout, diff} == ref_res)
      else $error("serial_subtractor: a=%h b=%h bin=%b got %b_%h",
                  sh_a, sh_b, sh_bin, bout, diff);
    end
  end
`endif

endmodule
